// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, QDEPTH-entry buffer, valid/ready output; push visible 1 cycle after ack.
// Backpressure: no new request while the buffer is full; redirect flushes the buffer and squashes any in-flight fetch.
module fetch_unit #(
   parameter int          QDEPTH   = 2,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [63:0] inst_pc,
   input  logic        inst_ready
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, WAIT, SQUASH} state_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] ins;
   } entry_t;

   state_t        state_q, state_d;
   logic [63:0]   pc_q, pc_d;
   logic [63:0]   addr_q, addr_d;
   logic          req_q, req_d;
   entry_t        mem_q [QDEPTH];
   entry_t        mem_d [QDEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push;
   logic          pop;
   logic [63:0]   redir_pc;

   assign redir_pc = redirect_pc & ~64'h3;
   // A redirect wins over a same-cycle pop: the head is discarded, not taken.
   assign pop      = (cnt_q != '0) && inst_ready && !redirect;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      req_d   = req_q;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            if (redirect) begin
               pc_d = redir_pc;
            end else if (cnt_q < CW'(QDEPTH)) begin
               req_d   = 1'b1;
               addr_d  = pc_q;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (imem_ack) begin
               push    = !redirect;
               pc_d    = redirect ? redir_pc : pc_q + 64'd4;
               req_d   = 1'b0;
               state_d = IDLE;
            end else if (redirect) begin
               pc_d    = redir_pc;
               state_d = SQUASH;
            end
         end
         SQUASH: begin
            if (redirect) begin
               pc_d = redir_pc;
            end
            if (imem_ack) begin
               req_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (redirect) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_q] = '{pc: addr_q, ins: imem_rdata};
            wr_d        = wr_q + PW'(1);
         end
         if (pop) begin
            rd_d = rd_q + PW'(1);
         end
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         req_q   <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         mem_q   <= mem_d;
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = addr_q;
   assign inst_valid = (cnt_q != '0);
   assign inst       = mem_q[rd_q].ins;
   assign inst_pc    = mem_q[rd_q].pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a queue-based reference model.
module tb_fetch_unit;

   localparam int QD = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        inst_ready;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] ins;
   } ent_t;

   always #5 clk = ~clk;

   fetch_unit #(.QDEPTH(QD), .RESET_PC(64'h0)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .inst_valid (inst_valid),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_ready (inst_ready)
   );

   task automatic clear_inputs();
      imem_ack    = 1'b0;
      imem_rdata  = '0;
      redirect    = 1'b0;
      redirect_pc = '0;
      inst_ready  = 1'b0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %0b want 0", imem_req); end
      n_cmp++; if (imem_addr !== 64'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", imem_addr); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b want 0", inst_valid); end
      n_cmp++; if (inst !== 32'h0) begin n_err++; $display("FAIL rst_inst got %h want 0", inst); end
      n_cmp++; if (inst_pc !== 64'h0) begin n_err++; $display("FAIL rst_inst_pc got %h want 0", inst_pc); end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req got %0b want 1", imem_req); end
      n_cmp++; if (imem_addr !== 64'h0) begin n_err++; $display("FAIL first_addr got %h want 0", imem_addr); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL first_valid got %0b want 0", inst_valid); end
   endtask

   task automatic test_basic();
      logic [31:0] words [3];
      int got;
      int nack;
      words[0] = 32'hAAAA_0001;
      words[1] = 32'hBBBB_0002;
      words[2] = 32'hCCCC_0003;
      got = 0;
      nack = 0;
      apply_reset();
      inst_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
         @(negedge clk);
         imem_ack = 1'b0;
         if (inst_valid) begin
            n_cmp++; if (inst !== words[got]) begin n_err++; $display("FAIL basic_inst[%0d] got %h want %h", got, inst, words[got]); end
            n_cmp++; if (inst_pc !== 64'(4 * got)) begin n_err++; $display("FAIL basic_pc[%0d] got %h want %h", got, inst_pc, 64'(4 * got)); end
            got++;
         end
         if (imem_req && nack < 3) begin
            imem_ack   = 1'b1;
            imem_rdata = words[nack];
            nack++;
         end
      end
      imem_ack = 1'b0;
      n_cmp++; if (got !== 3) begin n_err++; $display("FAIL basic_count got %0d want 3", got); end
   endtask

   task automatic test_backpressure();
      int nreq;
      bit found;
      nreq = 0;
      found = 0;
      apply_reset();
      inst_ready = 1'b0;
      repeat (12) begin
         @(negedge clk);
         imem_ack = 1'b0;
         if (imem_req) begin
            imem_ack   = 1'b1;
            imem_rdata = $urandom;
            nreq++;
         end
      end
      imem_ack = 1'b0;
      n_cmp++; if (nreq !== 2) begin n_err++; $display("FAIL bp_reqs got %0d want 2", nreq); end
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_req_full got %0b want 0", imem_req); end
      n_cmp++; if (inst_pc !== 64'h0) begin n_err++; $display("FAIL bp_head_pc got %h want 0", inst_pc); end
      inst_ready = 1'b1;
      for (int cyc = 0; cyc < 10 && !found; cyc++) begin
         @(negedge clk);
         if (imem_req) found = 1;
      end
      n_cmp++; if (!found) begin n_err++; $display("FAIL bp_resume got no req want req"); end
      n_cmp++; if (imem_addr !== 64'h8) begin n_err++; $display("FAIL bp_resume_addr got %h want 8", imem_addr); end
      inst_ready = 1'b0;
   endtask

   task automatic test_redirect_wait();
      bit saw_valid;
      bit found;
      saw_valid = 0;
      found = 0;
      apply_reset();
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rw_req got %0b want 1", imem_req); end
      redirect    = 1'b1;
      redirect_pc = 64'h100;
      @(negedge clk);
      redirect = 1'b0;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin n_err++; $display("FAIL rw_hold got req=%0b addr=%h want req=1 addr=0", imem_req, imem_addr); end
      @(negedge clk);
      @(negedge clk);
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      for (int cyc = 0; cyc < 10 && !found; cyc++) begin
         @(negedge clk);
         imem_ack = 1'b0;
         if (inst_valid) saw_valid = 1;
         if (imem_req) begin
            found = 1;
            n_cmp++; if (imem_addr !== 64'h100) begin n_err++; $display("FAIL rw_addr got %h want 100", imem_addr); end
            imem_ack   = 1'b1;
            imem_rdata = 32'h5555_AAAA;
         end
      end
      n_cmp++; if (!found) begin n_err++; $display("FAIL rw_new_req got none want req"); end
      n_cmp++; if (saw_valid) begin n_err++; $display("FAIL rw_squashed got valid=1 want 0"); end
      @(negedge clk);
      imem_ack = 1'b0;
      n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'h5555_AAAA || inst_pc !== 64'h100) begin
         n_err++; $display("FAIL rw_after got v=%0b %h@%h want 1 5555aaaa@100", inst_valid, inst, inst_pc);
      end
   endtask

   task automatic test_redirect_ack();
      apply_reset();
      @(negedge clk);
      imem_ack   = 1'b1;
      imem_rdata = 32'h0A0A_0A0A;
      @(negedge clk);
      imem_ack = 1'b0;
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h4 || inst_valid !== 1'b1) begin
         n_err++; $display("FAIL ra_setup got req=%0b addr=%h v=%0b want 1 4 1", imem_req, imem_addr, inst_valid);
      end
      imem_ack    = 1'b1;
      imem_rdata  = 32'h0B0B_0B0B;
      redirect    = 1'b1;
      redirect_pc = 64'h203;
      @(negedge clk);
      imem_ack = 1'b0;
      redirect = 1'b0;
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL ra_flush got %0b want 0", inst_valid); end
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL ra_req_drop got %0b want 0", imem_req); end
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h200) begin n_err++; $display("FAIL ra_next got req=%0b addr=%h want 1 200", imem_req, imem_addr); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL ra_dropped got %0b want 0", inst_valid); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      @(negedge clk);
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      @(negedge clk);
      imem_ack = 1'b0;
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h4) begin n_err++; $display("FAIL rm_setup got req=%0b addr=%h want 1 4", imem_req, imem_addr); end
      #2;
      reset      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'h7777_7777;
      #1;
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rm_req got %0b want 0", imem_req); end
      n_cmp++; if (imem_addr !== 64'h0) begin n_err++; $display("FAIL rm_addr got %h want 0", imem_addr); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid got %0b want 0", inst_valid); end
      n_cmp++; if (inst !== 32'h0 || inst_pc !== 64'h0) begin n_err++; $display("FAIL rm_head got %h@%h want 0@0", inst, inst_pc); end
      @(negedge clk);
      @(negedge clk);
      imem_ack = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rm_no_push got %0b want 0", inst_valid); end
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin n_err++; $display("FAIL rm_restart got req=%0b addr=%h want 1 0", imem_req, imem_addr); end
   endtask

   task automatic test_random();
      ent_t        q[$];
      ent_t        e;
      logic [63:0] m_pc, m_fa, rpc;
      bit          m_out, m_sq;
      int          occ;
      m_pc = 64'h0;
      m_fa = 64'h0;
      m_out = 0;
      m_sq = 0;
      apply_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc != 0) begin
            @(negedge clk);
            n_cmp++; if (imem_req !== m_out) begin n_err++; $display("FAIL rnd_req c%0d got %0b want %0b", cyc, imem_req, m_out); end
            if (m_out) begin
               n_cmp++; if (imem_addr !== m_fa) begin n_err++; $display("FAIL rnd_addr c%0d got %h want %h", cyc, imem_addr, m_fa); end
            end
            n_cmp++; if (inst_valid !== (q.size() > 0)) begin n_err++; $display("FAIL rnd_valid c%0d got %0b want %0b", cyc, inst_valid, q.size() > 0); end
            if (q.size() > 0) begin
               n_cmp++; if (inst !== q[0].ins || inst_pc !== q[0].pc) begin
                  n_err++; $display("FAIL rnd_head c%0d got %h@%h want %h@%h", cyc, inst, inst_pc, q[0].ins, q[0].pc);
               end
            end
            redirect = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
               0:       rpc = {$urandom, $urandom};
               1:       rpc = 64'hFFFF_FFFF_FFFF_FFF4;
               2:       rpc = 64'($urandom_range(0, 255));
               default: rpc = {32'h0, $urandom};
            endcase
            redirect_pc = rpc;
            imem_ack    = m_out && ($urandom_range(0, 2) == 0);
            imem_rdata  = $urandom;
            inst_ready  = $urandom_range(0, 1);
         end
         // Reference model for the coming clock edge.
         rpc = redirect_pc & ~64'h3;
         occ = q.size();
         if (occ > 0 && inst_ready && !redirect) void'(q.pop_front());
         if (m_out) begin
            if (imem_ack) begin
               if (!m_sq && !redirect) begin
                  e.pc  = m_fa;
                  e.ins = imem_rdata;
                  q.push_back(e);
               end
               if (redirect) m_pc = rpc;
               else if (!m_sq) m_pc = m_pc + 64'd4;
               m_out = 0;
            end else if (redirect) begin
               m_pc = rpc;
               m_sq = 1;
            end
         end else if (redirect) begin
            m_pc = rpc;
         end else if (occ < QD) begin
            m_out = 1;
            m_sq  = 0;
            m_fa  = m_pc;
         end
         if (redirect) q.delete();
      end
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      reset = 1'b0;
      clear_inputs();
      test_reset();
      test_basic();
      test_backpressure();
      test_redirect_wait();
      test_redirect_ack();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
